// File: rtl/spi_pkg.sv
// Shared definitions for the SPI port arbiter: FSM states, SPICR layout and divider width.
package spi_pkg;
    localparam int DIV_W      = 8;
    localparam int SPICR_W    = 11;
    localparam int CR_EN      = 10;
    localparam int CR_IRQ_EN  = 9;
    localparam int CR_IRQ_CLR = 8;

    typedef enum logic [2:0] {
        IDLE, CFG, LOAD, WBUSY, WDONE, READ, HOLD
    } state_t;

    // Control word that enables the port with interrupts off and the given divider.
    function automatic logic [SPICR_W-1:0] cfg_word(input logic [DIV_W-1:0] div);
        logic [SPICR_W-1:0] w;
        w             = '0;
        w[CR_EN]      = 1'b1;
        w[CR_IRQ_EN]  = 1'b0;
        w[CR_IRQ_CLR] = 1'b0;
        w[DIV_W-1:0]  = div;
        return w;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant to the first requester after ptr, wrapping at NREQ-1.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant
);
    localparam int PW = $clog2(NREQ);

    always_comb begin
        int            k;
        logic [PW-1:0] sel;
        k     = 0;
        sel   = '0;
        grant = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            sel = k[PW-1:0];
            if (req[sel] && grant == '0) grant[sel] = 1'b1;
        end
    end
endmodule

// File: rtl/spi_arb.sv
// Arbitrates NREQ byte requesters onto one SPI port (config, write, wait, read per byte).
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts a transfer stuck in the busy wait.
module spi_arb
    import spi_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [8*NREQ-1:0]  req_data,
    input  logic [NREQ-1:0]    req_last,
    input  logic [8*NREQ-1:0]  req_div,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [7:0]         rdata,
    output logic               err,
    output logic [10:0]        spi_din,
    output logic               spi_cmd,
    output logic               spi_wr,
    output logic               spi_rd,
    input  logic [8:0]         spi_dout
);
    localparam int PW = $clog2(NREQ);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   next_idx;
    logic [NREQ-1:0] arb_gnt;
    logic            last_q;
    logic            wd_hit;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt)
    );

    always_comb begin
        next_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (arb_gnt[i]) next_idx = PW'(i);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (state == WBUSY || state == WDONE)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end

    assign wd_hit = (state == WBUSY || state == WDONE) && (wd_cnt == TW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wd_hit         = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            rdata   <= '0;
            spi_din <= '0;
            spi_cmd <= 1'b0;
            spi_wr  <= 1'b0;
            spi_rd  <= 1'b0;
            ptr     <= PW'(NREQ - 1);
            owner   <= '0;
            last_q  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            err     <= 1'b0;
`endif
        end else begin
            spi_cmd <= 1'b0;
            spi_wr  <= 1'b0;
            spi_rd  <= 1'b0;
            done    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err     <= 1'b0;
`endif
            case (state)
                IDLE: if (|req) begin
                    owner   <= next_idx;
                    ptr     <= next_idx;
                    gnt     <= arb_gnt;
                    spi_cmd <= 1'b1;
                    spi_din <= cfg_word(req_div[8*next_idx +: 8]);
                    state   <= CFG;
                end
                CFG: begin
                    spi_wr  <= 1'b1;
                    spi_din <= {3'b000, req_data[8*owner +: 8]};
                    state   <= LOAD;
                end
                LOAD: begin
                    last_q <= req_last[owner];
                    state  <= WBUSY;
                end
                WBUSY: if (spi_dout[8]) state <= WDONE;
                WDONE: if (!spi_dout[8]) begin
                    spi_rd <= 1'b1;
                    rdata  <= spi_dout[7:0];
                    done   <= gnt;
                    state  <= READ;
                end
                READ: if (last_q) begin
                    gnt   <= '0;
                    state <= IDLE;
                end else begin
                    state <= HOLD;
                end
                // Divider is unchanged within a burst, so the next byte goes straight to LOAD.
                HOLD: if (req[owner]) begin
                    spi_wr  <= 1'b1;
                    spi_din <= {3'b000, req_data[8*owner +: 8]};
                    state   <= LOAD;
                end else begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef SPI_ARB_TIMEOUT_EN
            // Abort overrides the normal wait transition: disable the port, no done pulse.
            if (wd_hit) begin
                err     <= 1'b1;
                spi_cmd <= 1'b1;
                spi_rd  <= 1'b0;
                spi_din <= '0;
                done    <= '0;
                gnt     <= '0;
                state   <= IDLE;
            end
`endif
        end
    end
endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: vector table, scoreboarded strobes/done, multi-cycle corner cases.
module tb_spi_arb;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [8*NREQ-1:0] req_div = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        rdata;
    logic              err;
    logic [10:0]       spi_din;
    logic              spi_cmd;
    logic              spi_wr;
    logic              spi_rd;
    logic [8:0]        spi_dout;

    int n_chk  = 0;
    int n_fail = 0;
    bit err_ok = 1'b0;
    bit stuck  = 1'b0;

    typedef struct { bit is_wr; logic [10:0] din; logic [NREQ-1:0] gnt; } strobe_t;
    typedef struct { logic [NREQ-1:0] done; logic [7:0] rdata; } done_t;
    typedef struct {
        int idx; logic [7:0] data; logic [7:0] div;
        logic [10:0] cmd_din; logic [10:0] wr_din; logic [7:0] rdata;
    } vec_t;

    strobe_t sq[$];
    done_t   dq[$];

    spi_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_div  (req_div),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .spi_din  (spi_din),
        .spi_cmd  (spi_cmd),
        .spi_wr   (spi_wr),
        .spi_rd   (spi_rd),
        .spi_dout (spi_dout)
    );

    always #5 clk = ~clk;

    // SPI port model: busy for 4 cycles after a write, then returns the written byte xor 8'h99.
    logic       p_busy;
    logic [7:0] p_rx;
    logic [7:0] p_pend;
    int         p_cnt;
    assign spi_dout = {p_busy, p_rx};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_busy <= 1'b0; p_rx <= '0; p_pend <= '0; p_cnt <= 0;
        end else if (spi_wr) begin
            p_busy <= 1'b1; p_pend <= spi_din[7:0] ^ 8'h99; p_cnt <= 4;
        end else if (p_cnt > 0) begin
            p_cnt <= p_cnt - 1;
            if (p_cnt == 1 && !stuck) begin
                p_busy <= 1'b0; p_rx <= p_pend;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    function automatic logic [NREQ-1:0] gnt_of(input int idx);
        logic [NREQ-1:0] g;
        g = '0;
        g[idx] = 1'b1;
        return g;
    endfunction

    task automatic push_strobe(input bit w, input logic [10:0] d, input logic [NREQ-1:0] g);
        strobe_t s;
        s.is_wr = w; s.din = d; s.gnt = g;
        sq.push_back(s);
    endtask

    task automatic push_done(input int idx, input logic [7:0] wbyte);
        done_t d;
        d.done = gnt_of(idx); d.rdata = wbyte ^ 8'h99;
        dq.push_back(d);
    endtask

    // One byte as the port should see it: optional config, the write, then its done.
    task automatic expect_byte(input int idx, input logic [7:0] data, input logic [7:0] div, input bit with_cmd);
        if (with_cmd) push_strobe(1'b0, {3'b100, div}, gnt_of(idx));
        push_strobe(1'b1, {3'b000, data}, gnt_of(idx));
        push_done(idx, data);
    endtask

    task automatic set_req(input int idx, input logic [7:0] data, input logic [7:0] div, input bit last);
        req_data[8*idx +: 8] = data;
        req_div[8*idx +: 8]  = div;
        req_last[idx]        = last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int idx, input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            tick();
            if (done[idx]) break;
        end
        if (k == 200) fail_now(name);
    endtask

    task automatic wait_wr(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            tick();
            if (spi_wr) break;
        end
        if (k == 200) fail_now(name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_gnt"}, gnt, 0);
        check({name, "_done"}, done, 0);
        check({name, "_err"}, err, 0);
        check({name, "_rdata"}, rdata, 0);
        check({name, "_din"}, spi_din, 0);
        check({name, "_strobes"}, {spi_cmd, spi_wr, spi_rd}, 0);
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        strobe_t s;
        done_t   d;
        if (rst) begin
            if (spi_cmd || spi_wr || spi_rd)
                check("strobe_excl", $countones({spi_cmd, spi_wr, spi_rd}), 1);
            if (spi_cmd || spi_wr) begin
                if (sq.size() == 0) begin
                    check("unexpected_strobe", {spi_cmd, spi_wr}, 0);
                end else begin
                    s = sq.pop_front();
                    check("strobe_kind", spi_wr, s.is_wr);
                    check(s.is_wr ? "wr_din" : "cmd_din", spi_din, s.din);
                    check("strobe_gnt", gnt, s.gnt);
                end
            end
            if (done != '0) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    d = dq.pop_front();
                    check("done_owner", done, d.done);
                    check("done_rdata", rdata, d.rdata);
                    check("rd_with_done", spi_rd, 1);
                end
            end
            if (err && !err_ok) check("err_unexpected", err, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation budget expired");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        vec_t vt[4];
        int   cnt;
        vt[0] = '{0, 8'hA5, 8'h04, 11'h404, 11'h0A5, 8'h3C};
        vt[1] = '{1, 8'h00, 8'hFF, 11'h4FF, 11'h000, 8'h99};
        vt[2] = '{2, 8'hFF, 8'h01, 11'h401, 11'h0FF, 8'h66};
        vt[3] = '{3, 8'h5A, 8'h80, 11'h480, 11'h05A, 8'hC3};

        tick(); tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Single requests from the vector table.
        for (int v = 0; v < 4; v++) begin
            set_req(vt[v].idx, vt[v].data, vt[v].div, 1'b1);
            push_strobe(1'b0, vt[v].cmd_din, gnt_of(vt[v].idx));
            push_strobe(1'b1, vt[v].wr_din, gnt_of(vt[v].idx));
            push_done(vt[v].idx, vt[v].data);
            req[vt[v].idx] = 1'b1;
            wait_done(vt[v].idx, "vec_done");
            req[vt[v].idx] = 1'b0;
            check("vec_rdata", rdata, vt[v].rdata);
            tick();
            check("vec_release", gnt, 0);
        end

        // Contention: all four held, served 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h10 + 8'(i), 8'h20 + 8'(i), 1'b1);
        for (int k = 0; k < 5; k++) expect_byte(k % NREQ, 8'h10 + 8'(k % NREQ), 8'h20 + 8'(k % NREQ), 1'b1);
        req = '1;
        cnt = 0;
        for (int k = 0; k < 400 && cnt < 5; k++) begin
            tick();
            if (done != '0) cnt++;
        end
        if (cnt < 5) fail_now("contention_done");
        req = '0;
        tick();
        check("contention_release", gnt, 0);

        // Burst of three from requester 2 while requester 0 waits.
        set_req(2, 8'h11, 8'h42, 1'b0);
        set_req(0, 8'h77, 8'h08, 1'b1);
        expect_byte(2, 8'h11, 8'h42, 1'b1);
        expect_byte(2, 8'h22, 8'h42, 1'b0);
        expect_byte(2, 8'h33, 8'h42, 1'b0);
        expect_byte(0, 8'h77, 8'h08, 1'b1);
        req = 4'b0101;
        for (int b = 0; b < 3; b++) begin
            wait_done(2, "burst_done");
            check("burst_gnt", gnt, 4'b0100);
            if (b == 0) set_req(2, 8'h22, 8'h42, 1'b0);
            if (b == 1) set_req(2, 8'h33, 8'h42, 1'b1);
        end
        req[2] = 1'b0;
        tick();
        check("burst_release", gnt, 0);
        tick();
        check("burst_next_gnt", gnt, 4'b0001);
        wait_done(0, "burst_next_done");
        req[0] = 1'b0;
        tick();

        // HOLD release after the first byte of a non-last burst.
        set_req(1, 8'h3C, 8'h10, 1'b0);
        expect_byte(1, 8'h3C, 8'h10, 1'b1);
        req[1] = 1'b1;
        wait_done(1, "hold_done");
        req[1] = 1'b0;
        tick();
        check("hold_gnt_kept", gnt, 4'b0010);
        tick();
        check("hold_release", gnt, 0);
        tick(); tick(); tick();

        // Reset during WDONE, then check index 0 wins first.
        set_req(2, 8'h81, 8'h02, 1'b1);
        push_strobe(1'b0, 11'h402, 4'b0100);
        push_strobe(1'b1, 11'h081, 4'b0100);
        req[2] = 1'b1;
        wait_wr("rst_wr");
        tick(); tick();
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        req = '0;
        tick(); tick();
        rst = 1'b1;
        set_req(0, 8'hC3, 8'h01, 1'b1);
        set_req(3, 8'h0F, 8'h33, 1'b1);
        expect_byte(0, 8'hC3, 8'h01, 1'b1);
        expect_byte(3, 8'h0F, 8'h33, 1'b1);
        req = 4'b1001;
        wait_done(0, "postrst_done0");
        req[0] = 1'b0;
        wait_done(3, "postrst_done3");
        req[3] = 1'b0;
        tick();

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: port stays busy, owner 1 is aborted and requester 2 is served next.
        stuck  = 1'b1;
        err_ok = 1'b1;
        set_req(1, 8'h44, 8'h05, 1'b1);
        set_req(2, 8'h55, 8'h06, 1'b1);
        push_strobe(1'b0, 11'h405, 4'b0010);
        push_strobe(1'b1, 11'h044, 4'b0010);
        push_strobe(1'b0, 11'h000, 4'b0000);
        expect_byte(2, 8'h55, 8'h06, 1'b1);
        req = 4'b0110;
        wait_wr("to_wr");
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            cnt++;
            if (err) break;
        end
        check("to_err_latency", cnt, 17);
        check("to_err_pulse", err, 1);
        check("to_no_done", done, 0);
        check("to_release", gnt, 0);
        req[1] = 1'b0;
        stuck  = 1'b0;
        tick();
        err_ok = 1'b0;
        check("to_err_single", err, 0);
        wait_done(2, "to_next_done");
        req[2] = 1'b0;
        tick();
`endif

        tick(); tick();
        check("strobe_queue_empty", sq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT, default 4096: watchdog limit in clk cycles; used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester byte request, held until matching done pulse.
REQ-006 req_data  input  8*NREQ  byte to transmit, slice i for requester i.
REQ-007 req_last  input  NREQ  current byte is the last of the requester's burst.
REQ-008 req_div  input  8*NREQ  per-requester SCK baudrate divider.
REQ-009 gnt  output  NREQ  one-hot owner of the SPI port, zero when idle.
REQ-010 done  output  NREQ  one-cycle pulse to owner when its byte completes.
REQ-011 rdata  output  8  received byte, valid in the done cycle and held until the next done.
REQ-012 err  output  1  one-cycle pulse on watchdog abort.
REQ-013 spi_din  output  11  to SPI port din: {enable, irq_en, irq_clr, div[7:0]} on cmd, {3'b000, byte} on wr.
REQ-014 spi_cmd, spi_wr, spi_rd  output  1 each  single-cycle strobes to SPI port.
REQ-015 spi_dout  input  9  from SPI port: bit 8 busy, bits 7:0 data.

Function
REQ-016 States SHALL be IDLE, CFG, LOAD, WBUSY, WDONE, READ, HOLD.
REQ-017 IDLE: if any req bit is set, round-robin grant begins with the index after the last owner, wrapping at NREQ-1 to 0. The owner is latched and gnt is asserted on the next edge. The next state is CFG.
REQ-018 CFG: one-cycle spi_cmd with spi_din = {1,0,0,req_div[owner]}. The next state is LOAD.
REQ-019 LOAD: one-cycle spi_wr with spi_din = {3'b000,req_data[owner]}. The next state is WBUSY.
REQ-020 WBUSY: wait for spi_dout[8]=1, then go to WDONE. WDONE: wait for spi_dout[8]=0, then go to READ.
REQ-021 READ: one-cycle spi_rd. rdata is captured from spi_dout[7:0] and done[owner] is pulsed in the same cycle.
REQ-022 After READ, if req_last[owner] was 1 at LOAD, release gnt and return to IDLE. Otherwise go to HOLD.
REQ-023 HOLD: gnt is kept. If req[owner]=1, go to LOAD; CFG is skipped because the divider is unchanged. If req[owner]=0, release and go to IDLE.
REQ-024 Requests from non-owners are ignored until release. There is no preemption.
REQ-025 Strobes are mutually exclusive, and at most one strobe is issued per cycle.
REQ-026 The round-robin pointer is updated only on grant. A release followed by an immediate new request from the same requester still favours other pending requesters.
REQ-027 Minimum cycles from IDLE grant to done: 5 plus the SPI byte time.

Reset
REQ-028 While rst=0: state=IDLE, gnt=0, done=0, err=0, rdata=0, all spi strobes=0, spi_din=0, round-robin pointer=NREQ-1 so that index 0 wins first.
REQ-029 Reset asserted mid-transfer aborts immediately. No done pulse is issued.

Configuration
REQ-030 With SPI_ARB_TIMEOUT_EN defined, a counter runs in WBUSY and WDONE. If the count reaches TIMEOUT, the block pulses err, issues spi_cmd with spi_din=0 to disable the port, releases gnt, and returns to IDLE without a done pulse.
REQ-031 Without SPI_ARB_TIMEOUT_EN, the counter is not present, err is tied to 0, and the block waits indefinitely.

Structure
REQ-032 Shared package spi_pkg: state encodings, SPICR bit positions (enable=10, irq_en=9, irq_clr=8), and the divider width.
REQ-033 Round-robin selection SHALL be a separate sub-module rr_arbiter (inputs req and pointer; output one-hot grant). The FSM and datapath stay in spi_arb.

Verification
REQ-034 Single request: req=0001, req_data[0]=8'hA5, req_div[0]=8'd4, last=1, SPI port model echoes 8'h3C. Required response: cmd with spi_din=11'h404, then wr with spi_din=11'h0A5, then done[0] with rdata=8'h3C, then gnt=0.
REQ-035 Contention: req=1111 held with last=1 each. Required response: grants in order 0,1,2,3,0, one done each.
REQ-036 Burst: requester 2 sends 3 bytes with last on the third while req[0] is also set. Required response: exactly one cmd, three wr, and gnt stays 0100 until the third done, then moves to 0001.
REQ-037 HOLD release: owner drops req after the first of a non-last burst. Required response: gnt=0 and IDLE on the next cycle, with no extra wr.
REQ-038 Timeout (SPI_ARB_TIMEOUT_EN defined, TIMEOUT=16): busy held at 1. Required response: err pulse at cycle 16 of the wait, a cmd with spi_din=0, no done, and the next requester is served.
REQ-039 Reset mid-transfer: rst=0 during WDONE. Required response: all outputs are 0 asynchronously, and the first grant after reset goes to index 0.
